uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Sole owner of the UART_MASTER_Top write port (I_TX_EN/I_WADDR/I_WDATA).
//  After reset, programs the UART config registers: divisor, 8N1, FIFO enable.
//  Then shares the transmitter between two byte requesters:
//   - port 0: protocol responses (READY/ACK/IMAGE_RECEIVED), high priority.
//   - port 1: debug/status stream.
//  Paces every write on TxRDYn. Sits between the protocol FSMs and the UART.
// PARAMETERS
//  BAUD_DIV    16'd15    divisor written to DLL/DLM (27MHz/16/115200)
//  MAX_BURST   4'd8      max consecutive port-0 grants while port 1 is pending
//  BUSY_WIN    3'd4      cycles after a write to look for TxRDYn going high
//  TX_TIMEOUT  16'd8191  max cycles to wait for TxRDYn low before error
// PORTS
//  clk            in   1  27MHz system clock, single clock domain
//  reset_n        in   1  synchronous, active-low reset
//  req0_valid     in   1  port 0 has a byte; held until req0_ready
//  req0_data      in   8  port 0 byte; stable while req0_valid
//  req0_ready     out  1  one-cycle pulse: port 0 byte taken this cycle
//  req1_valid     in   1  port 1 has a byte; held until req1_ready
//  req1_data      in   8  port 1 byte
//  req1_ready     out  1  one-cycle pulse: port 1 byte taken this cycle
//  uart_tx_en     out  1  one-cycle write strobe to I_TX_EN
//  uart_waddr     out  3  UART register address
//  uart_wdata     out  8  UART register data
//  uart_tx_rdy_n  in   1  TxRDYn from UART, low = THR empty
//  init_done      out  1  high once the config sequence has completed
//  grant_id       out  1  source of the byte in flight (0/1)
//  busy           out  1  high in every state except IDLE
//  err_timeout    out  1  sticky; set when a TX_TIMEOUT expires
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge):
//   - Outputs: readies=0, uart_tx_en=0, uart_waddr=0, uart_wdata=0,
//     init_done=0, grant_id=0, busy=1, err_timeout=0.
//   - State=INIT_WR, cfg_idx=0, burst_cnt=0.
//   - Reset mid-transfer abandons the byte and reruns init.
//  Registered FSM states:
//   INIT_WR, INIT_WAIT, IDLE, GRANT, WRITE, WAIT_BUSY, WAIT_RDY.
//  Config table (cfg_idx 0..4), as addr/data:
//   3/0x83, 0/BAUD_DIV[7:0], 1/BAUD_DIV[15:8], 3/0x03, 2/0x07.
//  INIT_WR:
//   - Drive addr/data for cfg_idx with uart_tx_en=1 for exactly one cycle.
//   - Go to INIT_WAIT.
//  INIT_WAIT:
//   - Wait 2 cycles (register write, no TxRDYn dependency).
//   - cfg_idx++. At cfg_idx==5: init_done<=1, go to IDLE.
//   - Requests are never acknowledged before init_done.
//  IDLE:
//   - Acts when uart_tx_rdy_n==0 and any valid is high.
//   - Winner: port 0 if req0_valid, unless req1_valid and burst_cnt==MAX_BURST.
//   - Register reqN_ready<=1 and grant_id. Go to GRANT.
//  GRANT (ready pulse visible this cycle):
//   - Latch winner's data into uart_wdata, uart_waddr<=0, drop ready.
//   - burst_cnt: ++ on a port-0 win while req1_valid; else reset to 0.
//   - burst_cnt saturates at MAX_BURST.
//  WRITE:
//   - uart_tx_en=1 for one cycle. Go to WAIT_BUSY.
//   - Latency: valid seen in IDLE -> tx_en asserts 3 cycles later.
//  WAIT_BUSY:
//   - Go to WAIT_RDY on tx_rdy_n==1, or after BUSY_WIN cycles without it.
//   - This tolerates a UART that never shows a busy phase.
//  WAIT_RDY:
//   - On tx_rdy_n==0, go to IDLE.
//   - Counter hits TX_TIMEOUT: set err_timeout, go to IDLE.
//   - The byte is dropped on timeout, not retried.
//  Boundaries:
//   - Both valid in the same cycle: arbitration rule above, loser stays pending.
//   - valid dropped without ready: no effect. Requesters must not do this.
//   - uart_tx_en never asserts outside INIT_WR/WRITE.
//   - At most one byte in flight.
//   - Counters are fixed-width and saturating; none wrap.
// STRUCTURE
//  uart_pkg:
//   - UART register address constants (THR/DLL=0, DLM=1, FCR=2, LCR=3).
//   - LCR/FCR values.
//   - Protocol bytes (START_IMAGE 0x01, ACK 0x06, END_IMAGE 0x03,
//     IMAGE_RECEIVED 0x16).
//   - FSM state encodings.
//  Sub-module uart_cfg_rom: combinational cfg_idx -> {addr, data}, 5 entries.
// TESTING
//  1 Reset release: exactly 5 tx_en pulses, in order 3/83, 0/0F, 1/00, 3/03,
//    2/07. init_done=1 after the last pulse.
//  2 req0 0x06 after init, TxRDYn low:
//    - req0_ready pulses once.
//    - tx_en pulses 3 cycles after valid, waddr=0, wdata=06, grant_id=0.
//  3 Both valid every cycle (0x16 on port 0, 0x41 on port 1):
//    - Write pattern is 8x 0x16, then 1x 0x41, repeating.
//  4 TxRDYn held high for 10 cycles after a write: next tx_en waits until
//    TxRDYn goes low, never earlier.
//  5 TxRDYn stuck high after a write:
//    - err_timeout=1 after ~8191 cycles, FSM back in IDLE.
//    - Next request is served once TxRDYn goes low.
//  6 reset_n low during WAIT_RDY:
//    - Outputs at reset values next edge.
//    - Init sequence repeats in full. No ready pulse for the old request.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART register map, config values, protocol bytes and arbiter state encoding
package uart_pkg;

  localparam logic [2:0] ADDR_THR = 3'd0;
  localparam logic [2:0] ADDR_DLL = 3'd0;
  localparam logic [2:0] ADDR_DLM = 3'd1;
  localparam logic [2:0] ADDR_FCR = 3'd2;
  localparam logic [2:0] ADDR_LCR = 3'd3;

  localparam logic [7:0] LCR_DLAB_8N1 = 8'h83;
  localparam logic [7:0] LCR_8N1      = 8'h03;
  localparam logic [7:0] FCR_FIFO_EN  = 8'h07;

  localparam logic [7:0] PROTO_START_IMAGE    = 8'h01;
  localparam logic [7:0] PROTO_ACK            = 8'h06;
  localparam logic [7:0] PROTO_END_IMAGE      = 8'h03;
  localparam logic [7:0] PROTO_IMAGE_RECEIVED = 8'h16;

  localparam logic [2:0] CFG_LAST = 3'd4;

  typedef enum logic [2:0] {
    ST_INIT_WR,
    ST_INIT_WAIT,
    ST_IDLE,
    ST_GRANT,
    ST_WRITE,
    ST_WAIT_BUSY,
    ST_WAIT_RDY
  } arb_state_t;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } uart_wr_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester handshakes and UART write port seen by the arbiter
interface uart_tx_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       uart_tx_en;
  logic [2:0] uart_waddr;
  logic [7:0] uart_wdata;
  logic       uart_tx_rdy_n;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, uart_tx_rdy_n,
    output req0_ready, req1_ready, uart_tx_en, uart_waddr, uart_wdata
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, uart_tx_rdy_n,
    input  req0_ready, req1_ready, uart_tx_en, uart_waddr, uart_wdata
  );
endinterface

// File: rtl/uart_cfg_rom.sv
// rtl/uart_cfg_rom.sv - UART power-up register writes indexed by cfg_idx
module uart_cfg_rom
  import uart_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV = 16'd15
) (
  input  logic [2:0] cfg_idx,
  output uart_wr_t   cfg_wr
);

  // DLAB must be set before the divisor latches and cleared before the FIFO write.
  always_comb begin
    cfg_wr = '{addr: ADDR_THR, data: 8'h00};
    case (cfg_idx)
      3'd0:    cfg_wr = '{addr: ADDR_LCR, data: LCR_DLAB_8N1};
      3'd1:    cfg_wr = '{addr: ADDR_DLL, data: BAUD_DIV[7:0]};
      3'd2:    cfg_wr = '{addr: ADDR_DLM, data: BAUD_DIV[15:8]};
      3'd3:    cfg_wr = '{addr: ADDR_LCR, data: LCR_8N1};
      3'd4:    cfg_wr = '{addr: ADDR_FCR, data: FCR_FIFO_EN};
      default: cfg_wr = '{addr: ADDR_THR, data: 8'h00};
    endcase
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - UART write-port owner: config sequencer plus two-port byte arbiter
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV   = 16'd15,
  parameter logic [3:0]  MAX_BURST  = 4'd8,
  parameter logic [2:0]  BUSY_WIN   = 3'd4,
  parameter logic [15:0] TX_TIMEOUT = 16'd8191
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_tx_arbiter_if.master bus,
  output logic              init_done,
  output logic              grant_id,
  output logic              busy,
  output logic              err_timeout
);

  arb_state_t  state_q, state_d;
  logic [2:0]  cfg_idx_q, cfg_idx_d;
  logic [3:0]  burst_q, burst_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rdy0_q, rdy0_d;
  logic        rdy1_q, rdy1_d;
  logic        tx_en_q, tx_en_d;
  logic [2:0]  waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        gid_q, gid_d;
  logic        err_q, err_d;
  uart_wr_t    cfg_wr;
  logic        pick1;

  uart_cfg_rom #(.BAUD_DIV(BAUD_DIV)) u_cfg_rom (
    .cfg_idx (cfg_idx_q),
    .cfg_wr  (cfg_wr)
  );

  // Port 1 wins only when port 0 is absent or has used up its burst allowance.
  assign pick1 = !bus.req0_valid || (bus.req1_valid && burst_q == MAX_BURST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_INIT_WR;
      cfg_idx_q <= 3'd0;
      burst_q   <= 4'd0;
      cnt_q     <= 16'd0;
      rdy0_q    <= 1'b0;
      rdy1_q    <= 1'b0;
      tx_en_q   <= 1'b0;
      waddr_q   <= 3'd0;
      wdata_q   <= 8'h00;
      done_q    <= 1'b0;
      gid_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_idx_q <= cfg_idx_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      rdy0_q    <= rdy0_d;
      rdy1_q    <= rdy1_d;
      tx_en_q   <= tx_en_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      gid_q     <= gid_d;
      err_q     <= err_d;
    end
  end

  // Every action is registered, so strobes appear in the cycle after the state that requests them.
  always_comb begin
    state_d   = state_q;
    cfg_idx_d = cfg_idx_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    rdy0_d    = 1'b0;
    rdy1_d    = 1'b0;
    tx_en_d   = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    done_d    = done_q;
    gid_d     = gid_q;
    err_d     = err_q;
    case (state_q)
      ST_INIT_WR: begin
        tx_en_d = 1'b1;
        waddr_d = cfg_wr.addr;
        wdata_d = cfg_wr.data;
        cnt_d   = 16'd0;
        state_d = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        if (cnt_q == 16'd1) begin
          cnt_d     = 16'd0;
          cfg_idx_d = cfg_idx_q + 3'd1;
          if (cfg_idx_q == CFG_LAST) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_INIT_WR;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_IDLE: begin
        if (!bus.uart_tx_rdy_n && (bus.req0_valid || bus.req1_valid)) begin
          rdy0_d  = !pick1;
          rdy1_d  = pick1;
          gid_d   = pick1;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        waddr_d = ADDR_THR;
        wdata_d = gid_q ? bus.req1_data : bus.req0_data;
        if (!gid_q && bus.req1_valid) begin
          burst_d = (burst_q == MAX_BURST) ? burst_q : burst_q + 4'd1;
        end else begin
          burst_d = 4'd0;
        end
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        tx_en_d = 1'b1;
        cnt_d   = 16'd0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // Some UARTs never show a busy phase; give up watching after the window.
        if (bus.uart_tx_rdy_n || cnt_q == {13'd0, BUSY_WIN} - 16'd1) begin
          cnt_d   = 16'd0;
          state_d = ST_WAIT_RDY;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_WAIT_RDY: begin
        if (!bus.uart_tx_rdy_n) begin
          state_d = ST_IDLE;
        end else if (cnt_q == TX_TIMEOUT) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req0_ready = rdy0_q;
  assign bus.req1_ready = rdy1_q;
  assign bus.uart_tx_en = tx_en_q;
  assign bus.uart_waddr = waddr_q;
  assign bus.uart_wdata = wdata_q;
  assign init_done      = done_q;
  assign grant_id       = gid_q;
  assign busy           = (state_q != ST_IDLE);
  assign err_timeout    = err_q;

endmodule
